// File: rtl/acc_pkg.sv
// Shared types and register map for the accelerator sequencer.
// Word offsets are bus_addr[11:2] values inside the register region.
package acc_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RG_REG = 2'd0,
    RG_A   = 2'd1,
    RG_B   = 2'd2,
    RG_C   = 2'd3
  } region_e;

  localparam logic [9:0] REG_CTRL   = 10'd0;
  localparam logic [9:0] REG_STATUS = 10'd1;
  localparam logic [9:0] REG_CYCLES = 10'd2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_ERROR   = 3;

endpackage

// File: rtl/acc_cycle_cnt.sv
// RUN-cycle counter with clear/enable; hit_o flags count == TIMEOUT.
// Single-cycle update, no backpressure; the owner stops enabling at the limit.
module acc_cycle_cnt #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             hit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign hit_o = (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/acc_seq_ctrl.sv
// Bus-to-accelerator sequencer: operand writes, start/timeout FSM, C/status reads.
// Accepts every cycle (gnt = req); writes and reads complete one cycle later.
module acc_seq_ctrl
  import acc_pkg::*;
#(
  parameter int N_ELEM  = 1024,
  parameter int TIMEOUT = 65535,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_req,
  input  logic        bus_we,
  input  logic [13:0] bus_addr,
  input  logic [31:0] bus_wdata,
  output logic        bus_gnt,
  output logic        bus_rvalid,
  output logic [31:0] bus_rdata,
  output logic        acc_we,
  output logic        acc_sel,
  output logic [9:0]  acc_idx,
  output logic [7:0]  acc_wdata,
  output logic [9:0]  acc_rd_idx,
  input  logic [7:0]  acc_rdata,
  output logic        acc_start,
  input  logic        acc_done,
  output logic        acc_abort,
  output logic        irq
);

  state_e           state_q;
  region_e          region;
  logic [9:0]       idx;
  logic             idx_ok, wr, rd, busy;
  logic             ctrl_wr, ctrl_start, ctrl_clr, err_set;
  logic             done_q, to_q, err_q;
  logic             acc_we_q, acc_sel_q, acc_start_q, acc_abort_q, irq_q;
  logic [9:0]       acc_idx_q;
  logic [7:0]       acc_wdata_q;
  logic             rvalid_q, c_rd_q;
  logic [31:0]      rdata_q, reg_rdata;
  logic             cnt_clr, cnt_en, cnt_hit;
  logic [CNT_W-1:0] cnt;
  logic             unused_wdata;

  assign region       = region_e'(bus_addr[13:12]);
  assign idx          = bus_addr[11:2];
  assign idx_ok       = (int'(idx) < N_ELEM);
  assign wr           = bus_req & bus_we;
  assign rd           = bus_req & ~bus_we;
  assign busy         = (state_q == S_START) | (state_q == S_RUN);
  assign ctrl_wr      = wr & (region == RG_REG) & (idx == REG_CTRL);
  assign ctrl_start   = ctrl_wr & bus_wdata[0];
  assign ctrl_clr     = ctrl_wr & bus_wdata[1];
  assign unused_wdata = ^bus_wdata[31:8];

  always_comb begin
    err_set = 1'b0;
    if (wr) begin
      case (region)
        RG_REG: begin
          if (idx == REG_CTRL)
            err_set = ctrl_start & busy;
          else if (idx != REG_STATUS && idx != REG_CYCLES)
            err_set = 1'b1;
        end
        RG_A, RG_B: err_set = busy | ~idx_ok;
        default:    err_set = 1'b1;
      endcase
    end else if (rd && region == RG_C) begin
      err_set = busy | ~idx_ok;
    end
  end

  always_comb begin
    reg_rdata = '0;
    if (region == RG_REG) begin
      if (idx == REG_STATUS) begin
        reg_rdata[STAT_BUSY]    = busy;
        reg_rdata[STAT_DONE]    = done_q;
        reg_rdata[STAT_TIMEOUT] = to_q;
        reg_rdata[STAT_ERROR]   = err_q;
      end else if (idx == REG_CYCLES) begin
        reg_rdata[CNT_W-1:0] = cnt;
      end
    end
  end

  // Counting stops on the hit cycle so CYCLES reads back exactly TIMEOUT.
  assign cnt_clr = (state_q == S_START);
  assign cnt_en  = (state_q == S_RUN) & ~acc_done & ~cnt_hit;

  acc_cycle_cnt #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .cnt_o (cnt),
    .hit_o (cnt_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_we_q    <= 1'b0;
      acc_sel_q   <= 1'b0;
      acc_idx_q   <= '0;
      acc_wdata_q <= '0;
      rvalid_q    <= 1'b0;
      c_rd_q      <= 1'b0;
      rdata_q     <= '0;
    end else begin
      acc_we_q <= wr & ((region == RG_A) | (region == RG_B)) & ~busy & idx_ok;
      if (wr) begin
        acc_sel_q   <= (region == RG_B);
        acc_idx_q   <= idx;
        acc_wdata_q <= bus_wdata[7:0];
      end
      rvalid_q <= rd;
      c_rd_q   <= rd & (region == RG_C) & ~busy & idx_ok;
      rdata_q  <= rd ? reg_rdata : '0;
    end
  end

  // Clear is applied before any set in the same cycle, so later NBAs win.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      done_q      <= 1'b0;
      to_q        <= 1'b0;
      err_q       <= 1'b0;
      acc_start_q <= 1'b0;
      acc_abort_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      acc_start_q <= 1'b0;
      acc_abort_q <= 1'b0;
      if (ctrl_clr) begin
        done_q <= 1'b0;
        to_q   <= 1'b0;
        err_q  <= 1'b0;
      end
      if (err_set)
        err_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (ctrl_start) begin
            state_q     <= S_START;
            acc_start_q <= 1'b1;
          end
        end
        S_START: state_q <= S_RUN;
        S_RUN: begin
          if (acc_done) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            irq_q   <= 1'b1;
          end else if (cnt_hit) begin
            state_q     <= S_DONE;
            to_q        <= 1'b1;
            acc_abort_q <= 1'b1;
            irq_q       <= 1'b1;
          end
        end
        S_DONE: begin
          if (ctrl_start) begin
            state_q     <= S_START;
            acc_start_q <= 1'b1;
            irq_q       <= 1'b0;
          end else if (ctrl_clr) begin
            state_q <= S_IDLE;
            irq_q   <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_gnt    = bus_req;
  assign bus_rvalid = rvalid_q;
  assign bus_rdata  = c_rd_q ? {24'b0, acc_rdata} : rdata_q;
  assign acc_we     = acc_we_q;
  assign acc_sel    = acc_sel_q;
  assign acc_idx    = acc_idx_q;
  assign acc_wdata  = acc_wdata_q;
  assign acc_rd_idx = (rd && region == RG_C) ? idx : '0;
  assign acc_start  = acc_start_q;
  assign acc_abort  = acc_abort_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Directed bench for acc_seq_ctrl with a short TIMEOUT so the limit is reachable.
module tb_acc_seq_ctrl;

  localparam logic [13:0] A_CTRL   = 14'h0000;
  localparam logic [13:0] A_STATUS = 14'h0004;
  localparam logic [13:0] A_CYCLES = 14'h0008;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_req, bus_we;
  logic [13:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;
  logic        acc_we, acc_sel;
  logic [9:0]  acc_idx, acc_rd_idx;
  logic [7:0]  acc_wdata, acc_rdata;
  logic        acc_start, acc_done, acc_abort, irq;

  int n_chk  = 0;
  int n_fail = 0;

  acc_seq_ctrl #(
    .N_ELEM  (1024),
    .TIMEOUT (8),
    .CNT_W   (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata),
    .acc_we     (acc_we),
    .acc_sel    (acc_sel),
    .acc_idx    (acc_idx),
    .acc_wdata  (acc_wdata),
    .acc_rd_idx (acc_rd_idx),
    .acc_rdata  (acc_rdata),
    .acc_start  (acc_start),
    .acc_done   (acc_done),
    .acc_abort  (acc_abort),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [13:0] addr, input logic [31:0] data);
    bus_req   = 1'b1;
    bus_we    = 1'b1;
    bus_addr  = addr;
    bus_wdata = data;
    tick();
    bus_req   = 1'b0;
    bus_we    = 1'b0;
  endtask

  // C memory model: element i holds 0xA4 + i, returned the cycle after the index.
  task automatic bus_read(input logic [13:0] addr, output logic [31:0] d,
                          output logic v, output logic [9:0] rd_idx);
    bus_req  = 1'b1;
    bus_we   = 1'b0;
    bus_addr = addr;
    #1;
    rd_idx   = acc_rd_idx;
    @(posedge clk);
    #1;
    bus_req   = 1'b0;
    acc_rdata = 8'hA4 + addr[9:2];
    #1;
    d = bus_rdata;
    v = bus_rvalid;
  endtask

  task automatic read_reg(input string tag, input logic [13:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        v;
    logic [9:0]  ri;
    bus_read(addr, d, v, ri);
    check(tag, d, exp);
  endtask

  task automatic pulse_done();
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
  endtask

  logic [31:0] rd_d;
  logic        rd_v;
  logic [9:0]  rd_i;
  int          found, when_seen, pulses;

  initial begin
    rst = 1'b1; bus_req = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    acc_rdata = '0; acc_done = 1'b0;
    repeat (3) tick();
    check("reset_outs", 32'(|{bus_gnt, bus_rvalid, bus_rdata, acc_we, acc_sel, acc_idx,
                              acc_wdata, acc_rd_idx, acc_start, acc_abort, irq}), 0);
    rst = 1'b0;
    read_reg("reset_status", A_STATUS, 32'h0);
    read_reg("reset_cycles", A_CYCLES, 32'h0);

    // Operand writes from IDLE, back to back
    bus_write(14'h1000, 32'hFFFF_FF12);
    check("wrA_we", acc_we, 1);
    check("wrA_sel_idx_dat", {acc_sel, acc_idx, acc_wdata}, {1'b0, 10'd0, 8'h12});
    bus_write(14'h2FFC, 32'h0000_0034);
    check("wrB_we", acc_we, 1);
    check("wrB_sel_idx_dat", {acc_sel, acc_idx, acc_wdata}, {1'b1, 10'd1023, 8'h34});
    tick();
    check("wr_we_drop", acc_we, 0);

    // Write to C is an error; clear in IDLE removes it
    bus_write(14'h3000, 32'h55);
    check("wrC_no_we", acc_we, 0);
    read_reg("wrC_status", A_STATUS, 32'h8);
    bus_write(A_CTRL, 32'h2);
    read_reg("idle_clear_status", A_STATUS, 32'h0);

    // Normal run: done on 5th RUN cycle
    bus_write(A_CTRL, 32'h1);
    check("run_start_hi", acc_start, 1);
    tick();
    check("run_start_lo", acc_start, 0);
    repeat (4) tick();
    check("run_irq_pre", irq, 0);
    pulse_done();
    check("run_irq", irq, 1);
    read_reg("run_status", A_STATUS, 32'h2);
    read_reg("run_cycles", A_CYCLES, 32'h4);
    bus_read(14'h301C, rd_d, rd_v, rd_i);
    check("c_rd_idx", rd_i, 10'd7);
    check("c_rvalid", rd_v, 1);
    check("c_rdata", rd_d, 32'h0000_00AB);
    tick();
    check("c_rvalid_lo", bus_rvalid, 0);
    bus_write(A_CTRL, 32'h2);
    check("clr_irq", irq, 0);

    // Timeout: abort exactly 10 cycles after the accepted start
    bus_write(A_CTRL, 32'h1);
    found = 0; when_seen = 0; pulses = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (acc_abort) begin
        pulses++;
        if (found == 0) begin
          found     = 1;
          when_seen = i;
        end
      end
    end
    check("to_abort_seen", found, 1);
    check("to_abort_cycle", when_seen, 10);
    check("to_abort_width", pulses, 1);
    check("to_irq", irq, 1);
    read_reg("to_status", A_STATUS, 32'h4);
    read_reg("to_cycles", A_CYCLES, 32'h8);
    bus_write(A_CTRL, 32'h2);

    // Busy interlocks during RUN
    bus_write(A_CTRL, 32'h1);
    tick();
    bus_write(14'h100C, 32'h77);
    check("busy_wr_dropped", acc_we, 0);
    bus_write(A_CTRL, 32'h1);
    check("busy_no_restart", acc_start, 0);
    bus_read(14'h301C, rd_d, rd_v, rd_i);
    check("busy_c_rd_zero", rd_d, 32'h0);
    read_reg("busy_status", A_STATUS, 32'h9);
    pulse_done();
    read_reg("busy_done_status", A_STATUS, 32'hA);
    bus_write(A_CTRL, 32'h2);
    check("busy_clr_irq", irq, 0);
    read_reg("busy_clr_status", A_STATUS, 32'h0);

    // Done coincides with counter reaching TIMEOUT: done wins
    bus_write(A_CTRL, 32'h1);
    repeat (9) tick();
    pulse_done();
    check("tie_no_abort", acc_abort, 0);
    check("tie_irq", irq, 1);
    read_reg("tie_status", A_STATUS, 32'h2);
    read_reg("tie_cycles", A_CYCLES, 32'h8);

    // Reset mid-RUN, then a normal run (start+clear from DONE first)
    bus_write(A_CTRL, 32'h3);
    check("both_start", acc_start, 1);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("rst_outs", 32'(|{bus_gnt, bus_rvalid, bus_rdata, acc_we, acc_sel, acc_idx,
                            acc_wdata, acc_rd_idx, acc_start, acc_abort, irq}), 0);
    rst = 1'b0;
    read_reg("rst_status", A_STATUS, 32'h0);
    bus_write(A_CTRL, 32'h1);
    check("rst_restart", acc_start, 1);
    repeat (3) tick();
    pulse_done();
    check("rst_run_irq", irq, 1);
    read_reg("rst_run_status", A_STATUS, 32'h2);
    read_reg("rst_run_cycles", A_CYCLES, 32'h2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
